// File: rtl/johnson_counter_param_if.sv
// Control/status bundle of the parametrised Johnson counter.
// The phase-index width is derived from WIDTH so that the interface and the
// counter always agree on how wide a phase number is.
interface johnson_counter_param_if #(
    parameter int WIDTH = 4
);
    localparam int PHASE_W = $clog2(2 * WIDTH);

    logic               sync_clear;
    logic               en;
    logic               up;
    logic               load;
    logic [PHASE_W-1:0] load_phase;
    logic [WIDTH-1:0]   out;
    logic [PHASE_W-1:0] phase;
    logic               tc;
    logic               err;

    // Controller side: drives the commands, observes the ring.
    modport master (
        output sync_clear, en, up, load, load_phase,
        input  out, phase, tc, err
    );

    // Counter side: takes the commands, presents the ring and its decode.
    modport slave (
        input  sync_clear, en, up, load, load_phase,
        output out, phase, tc, err
    );
endinterface

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) phase sequencer, updated on the falling
// edge of clk. Provides count enable, up/down direction, parallel phase load,
// binary phase decode, terminal-count look-ahead and a sticky error flag that
// is raised on a bad load or when the ring is found in a non-Johnson state
// (the ring is then forced back to phase 0).
module johnson_counter_param #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic async_reset_n,
    johnson_counter_param_if.slave bus
);
    localparam int PHASE_W = $clog2(2 * WIDTH);

    localparam logic [PHASE_W:0]   LP_TWO_W = (PHASE_W + 1)'(2 * WIDTH);
    localparam logic [PHASE_W-1:0] LP_LAST  = PHASE_W'(2 * WIDTH - 1);
    localparam logic [PHASE_W-1:0] LP_FIRST = '0;

    // What the next falling edge will do to the ring, in priority order.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CLEAR,
        ACT_LOAD,
        ACT_BAD_LOAD,
        ACT_RECOVER,
        ACT_STEP_UP,
        ACT_STEP_DOWN
    } action_t;

    logic [WIDTH-1:0]   r_out;
    logic               r_err;
    logic               r_running;

    logic [PHASE_W:0]   w_edgeCount;
    logic [PHASE_W:0]   w_popCount;
    logic               w_legal;
    logic               w_badLoad;
    logic [PHASE_W-1:0] w_phase;
    action_t            w_action;
    logic [WIDTH-1:0]   w_nextOut;
    logic               w_nextErr;

    // Johnson code for a phase index: phases up to WIDTH fill ones from bit 0
    // upward, later phases drain them again from bit 0, leaving the top ones.
    function automatic logic [WIDTH-1:0] phaseToCode(input logic [PHASE_W-1:0] k);
        logic [WIDTH-1:0] code;
        int               kInt;
        code = '0;
        kInt = int'(k);
        for (int i = 0; i < WIDTH; i++) begin
            if (kInt <= WIDTH) begin
                code[i] = (i < kInt);
            end else begin
                code[i] = (i >= kInt - WIDTH);
            end
        end
        return code;
    endfunction

    // A Johnson code has at most one boundary between a run of ones and a run
    // of zeros; count the adjacent-bit boundaries and the ones in the ring.
    always_comb begin
        w_edgeCount = '0;
        w_popCount  = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            w_edgeCount = w_edgeCount + (PHASE_W + 1)'(r_out[i] ^ r_out[i+1]);
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_popCount = w_popCount + (PHASE_W + 1)'(r_out[i]);
        end
    end

    assign w_legal   = (w_edgeCount <= (PHASE_W + 1)'(1));
    assign w_badLoad = ({1'b0, bus.load_phase} >= LP_TWO_W);

    // Binary phase: rising half counts the ones, falling half counts down from
    // 2*WIDTH; a corrupted ring reports phase 0 until it is recovered.
    always_comb begin
        w_phase = '0;
        if (w_legal) begin
            if (r_out[WIDTH-1] == 1'b0) begin
                w_phase = PHASE_W'(w_popCount);
            end else begin
                w_phase = PHASE_W'(LP_TWO_W - w_popCount);
            end
        end
    end

    // Pick the single action for the coming edge: clear beats load, load beats
    // recovery, recovery beats counting, and recovery ignores the enable.
    always_comb begin
        w_action = ACT_HOLD;
        if (bus.sync_clear) begin
            w_action = ACT_CLEAR;
        end else if (bus.load) begin
            w_action = w_badLoad ? ACT_BAD_LOAD : ACT_LOAD;
        end else if (!w_legal) begin
            w_action = ACT_RECOVER;
        end else if (bus.en) begin
            w_action = bus.up ? ACT_STEP_UP : ACT_STEP_DOWN;
        end
    end

    // Translate the chosen action into the next ring value and error flag.
    always_comb begin
        w_nextOut = r_out;
        w_nextErr = r_err;
        case (w_action)
            ACT_CLEAR: begin
                w_nextOut = '0;
                w_nextErr = 1'b0;
            end
            ACT_LOAD: begin
                w_nextOut = phaseToCode(bus.load_phase);
            end
            ACT_BAD_LOAD, ACT_RECOVER: begin
                w_nextOut = '0;
                w_nextErr = 1'b1;
            end
            ACT_STEP_UP: begin
                w_nextOut = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};
            end
            ACT_STEP_DOWN: begin
                w_nextOut = {~r_out[0], r_out[WIDTH-1:1]};
            end
            default: begin
                w_nextOut = r_out;
                w_nextErr = r_err;
            end
        endcase
    end

    // Ring and error state on the falling edge; the first falling edge after
    // reset removal only arms r_running, so nothing moves on the release edge.
    always_ff @(negedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_out     <= '0;
            r_err     <= 1'b0;
            r_running <= 1'b0;
        end else if (!r_running) begin
            r_running <= 1'b1;
        end else begin
            r_out <= w_nextOut;
            r_err <= w_nextErr;
        end
    end

    assign bus.out   = r_out;
    assign bus.err   = r_err;
    assign bus.phase = w_phase;
    assign bus.tc    = bus.en & ~bus.load & ~bus.sync_clear & w_legal &
                       ((bus.up & (w_phase == LP_LAST)) | (~bus.up & (w_phase == LP_FIRST)));
endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench for the Johnson counter: a 4-bit and a 5-bit instance share
// one clock and are exercised in turn with hand-computed expected values.
module tb_johnson_counter_param;
   logic clk;
   logic rst4N;
   logic rst5N;
   int   checks;
   int   failures;

   johnson_counter_param_if #(.WIDTH(4)) bus4 ();
   johnson_counter_param_if #(.WIDTH(5)) bus5 ();

   johnson_counter_param #(.WIDTH(4)) dut4 (
      .clk           (clk),
      .async_reset_n (rst4N),
      .bus           (bus4)
   );

   johnson_counter_param #(.WIDTH(5)) dut5 (
      .clk           (clk),
      .async_reset_n (rst5N),
      .bus           (bus5)
   );

   // Free-running clock; the counter acts on the falling edge.
   initial clk = 1'b1;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and log a failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive all command inputs of the 4-bit instance at once.
   task automatic applyStimulus(input logic clr, input logic enable, input logic dirUp,
                                input logic ld, input logic [2:0] ldPhase);
      bus4.sync_clear = clr;
      bus4.en         = enable;
      bus4.up         = dirUp;
      bus4.load       = ld;
      bus4.load_phase = ldPhase;
   endtask

   // Advance to just after the next falling edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Directed sequence covering counting, loading, recovery, reset and wrap.
   initial begin
      logic [3:0] upSeq4 [9];
      logic [2:0] upPh4  [9];
      logic [4:0] upSeq5 [10];

      upSeq4 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
      upPh4  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
      upSeq5 = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                 5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
      checks   = 0;
      failures = 0;

      rst4N = 1'b0;
      rst5N = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      bus5.sync_clear = 1'b0;
      bus5.en         = 1'b0;
      bus5.up         = 1'b0;
      bus5.load       = 1'b0;
      bus5.load_phase = '0;
      #2;

      $display("[TB] reset state and up count, WIDTH=4");
      checkOutput("rst_out", 32'(bus4.out), 32'h0);
      checkOutput("rst_err", 32'(bus4.err), 32'h0);
      checkOutput("rst_phase", 32'(bus4.phase), 32'h0);
      checkOutput("rst_tc", 32'(bus4.tc), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      rst4N = 1'b1;
      tick();
      checkOutput("release_edge_out", 32'(bus4.out), 32'h0);
      for (int i = 0; i < 9; i++) begin
         tick();
         checkOutput("up_out", 32'(bus4.out), 32'(upSeq4[i]));
         checkOutput("up_phase", 32'(bus4.phase), 32'(upPh4[i]));
         checkOutput("up_tc", 32'(bus4.tc), (upPh4[i] == 3'd7) ? 32'h1 : 32'h0);
      end

      $display("[TB] down count and direction change");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      #2;
      rst4N = 1'b0;
      #1;
      checkOutput("down_rst_out", 32'(bus4.out), 32'h0);
      checkOutput("down_tc_phase0", 32'(bus4.tc), 32'h1);
      rst4N = 1'b1;
      tick();
      checkOutput("down_release_out", 32'(bus4.out), 32'h0);
      tick();
      checkOutput("down1_out", 32'(bus4.out), 32'h8);
      checkOutput("down1_phase", 32'(bus4.phase), 32'd7);
      checkOutput("down1_tc", 32'(bus4.tc), 32'h0);
      tick();
      checkOutput("down2_out", 32'(bus4.out), 32'hC);
      checkOutput("down2_phase", 32'(bus4.phase), 32'd6);
      tick();
      checkOutput("down3_out", 32'(bus4.out), 32'hE);
      checkOutput("down3_phase", 32'(bus4.phase), 32'd5);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      tick();
      checkOutput("reverse_out", 32'(bus4.out), 32'hC);
      checkOutput("reverse_phase", 32'(bus4.phase), 32'd6);

      $display("[TB] parallel load, WIDTH=4");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
      tick();
      checkOutput("load5_out", 32'(bus4.out), 32'hE);
      checkOutput("load5_phase", 32'(bus4.phase), 32'd5);
      checkOutput("load5_err", 32'(bus4.err), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd4);
      tick();
      checkOutput("load4_out", 32'(bus4.out), 32'hF);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd7);
      tick();
      checkOutput("load7_out", 32'(bus4.out), 32'h8);
      checkOutput("load_blocks_tc", 32'(bus4.tc), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      #1;
      checkOutput("tc_phase7", 32'(bus4.tc), 32'h1);
      tick();
      checkOutput("wrap_up_out", 32'(bus4.out), 32'h0);
      checkOutput("wrap_up_tc", 32'(bus4.tc), 32'h0);

      $display("[TB] illegal state recovery, WIDTH=4");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
      force dut4.r_out = 4'b0101;
      #1;
      release dut4.r_out;
      #1;
      checkOutput("illegal_out", 32'(bus4.out), 32'h5);
      checkOutput("illegal_phase", 32'(bus4.phase), 32'h0);
      tick();
      checkOutput("recover_out", 32'(bus4.out), 32'h0);
      checkOutput("recover_err", 32'(bus4.err), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("err_sticky", 32'(bus4.err), 32'h1);
      end
      checkOutput("count_after_err", 32'(bus4.out), 32'h3);

      $display("[TB] async reset mid-count, WIDTH=4");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      tick();
      checkOutput("clear_err", 32'(bus4.err), 32'h0);
      checkOutput("clear_out", 32'(bus4.out), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      tick();
      tick();
      tick();
      checkOutput("pre_reset_out", 32'(bus4.out), 32'h7);
      checkOutput("pre_reset_phase", 32'(bus4.phase), 32'd3);
      #2;
      rst4N = 1'b0;
      #1;
      checkOutput("mid_reset_out", 32'(bus4.out), 32'h0);
      checkOutput("mid_reset_phase", 32'(bus4.phase), 32'h0);
      rst4N = 1'b1;
      tick();
      checkOutput("removal_edge_out", 32'(bus4.out), 32'h0);
      tick();
      checkOutput("first_count_out", 32'(bus4.out), 32'h1);

      $display("[TB] WIDTH=5 full cycle, priority and bad load");
      bus5.en = 1'b1;
      bus5.up = 1'b1;
      rst5N   = 1'b1;
      tick();
      checkOutput("w5_release_out", 32'(bus5.out), 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("w5_up_out", 32'(bus5.out), 32'(upSeq5[i]));
         checkOutput("w5_up_phase", 32'(bus5.phase), 32'((i + 1) % 10));
         checkOutput("w5_up_tc", 32'(bus5.tc), (i == 8) ? 32'h1 : 32'h0);
      end
      tick();
      @(posedge clk);
      #1;
      checkOutput("w5_rising_hold", 32'(bus5.out), 32'h01);
      @(negedge clk);
      #1;
      bus5.en         = 1'b0;
      bus5.load       = 1'b1;
      bus5.load_phase = 4'd3;
      tick();
      checkOutput("w5_load3_out", 32'(bus5.out), 32'h07);
      bus5.en         = 1'b1;
      bus5.load_phase = 4'd6;
      bus5.sync_clear = 1'b1;
      #1;
      checkOutput("w5_all_tc", 32'(bus5.tc), 32'h0);
      tick();
      checkOutput("w5_clear_wins", 32'(bus5.out), 32'h00);
      bus5.sync_clear = 1'b0;
      bus5.load_phase = 4'd12;
      tick();
      checkOutput("w5_badload_out", 32'(bus5.out), 32'h00);
      checkOutput("w5_badload_err", 32'(bus5.err), 32'h1);
      bus5.load_phase = 4'd9;
      tick();
      checkOutput("w5_load9_out", 32'(bus5.out), 32'h10);
      checkOutput("w5_load9_phase", 32'(bus5.phase), 32'd9);
      checkOutput("w5_err_kept", 32'(bus5.err), 32'h1);
      bus5.load = 1'b0;
      bus5.up   = 1'b1;
      tick();
      checkOutput("w5_wrap_out", 32'(bus5.out), 32'h00);
      bus5.up = 1'b0;
      tick();
      checkOutput("w5_down_wrap_out", 32'(bus5.out), 32'h10);
      checkOutput("w5_down_wrap_phase", 32'(bus5.phase), 32'd9);
      bus5.en         = 1'b0;
      bus5.sync_clear = 1'b1;
      tick();
      checkOutput("w5_clear_err", 32'(bus5.err), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
